// File: rtl/puc_seq.sv
// Uncore power-up sequencer: powers each contract-permitted domain in index order, then releases the shared reset.
// Define PUC_SEQ_TIMEOUT_EN to bound the wait for power-good by TIMEOUT cycles.
module puc_seq #(
    parameter  int unsigned N_DOM   = 2,
    parameter  int unsigned SETTLE  = 4,
    parameter  int unsigned TIMEOUT = 255,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [N_DOM-1:0] puc_i,
    input  logic             start_i,
    input  logic             clr_i,
    input  logic [N_DOM-1:0] pg_i,
    output logic [N_DOM-1:0] pwr_en_o,
    output logic [N_DOM-1:0] iso_o,
    output logic             dom_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IDX_W-1:0] err_dom_o
);

    if (N_DOM < 1 || SETTLE < 1 ||
        $clog2(SETTLE + 1) > CNT_W || $clog2(TIMEOUT + 1) > CNT_W) begin : g_bad_cfg
        $error("puc_seq: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PWR_ON, S_WAIT_PG, S_SETTLE, S_NEXT, S_RELEASE, S_DONE, S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [N_DOM-1:0]   cap_q, cap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DOM-1:0]   pwr_en_q, pwr_en_d;
    logic [N_DOM-1:0]   iso_q, iso_d;
    logic               dom_reset_q, dom_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_dom_q, err_dom_d;

    logic               drop;
    logic [IDX_W-1:0]   drop_idx;

    // Lowest-index permitted domain whose power-good has fallen
    always_comb begin
        drop     = 1'b0;
        drop_idx = '0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (cap_q[i] && !pg_i[i]) begin
                drop     = 1'b1;
                drop_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        logic             go_err;
        logic             go_idle;
        logic [IDX_W-1:0] err_idx;

        state_d     = state_q;
        cap_d       = cap_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pwr_en_d    = pwr_en_q;
        iso_d       = iso_q;
        dom_reset_d = dom_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_dom_d   = err_dom_q;
        go_err      = 1'b0;
        go_idle     = 1'b0;
        err_idx     = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cap_d   = puc_i;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_PWR_ON;
                end
            end
            S_PWR_ON: begin
                if (!cap_q[idx_q]) begin
                    state_d = S_NEXT;
                end else begin
                    pwr_en_d[idx_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = S_WAIT_PG;
                end
            end
            S_WAIT_PG: begin
                if (pg_i[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
`ifdef PUC_SEQ_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT)) begin
                        go_err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    iso_d[idx_q] = 1'b0;
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                // Release becomes visible in the cycle right after the final NEXT
                if (idx_q == IDX_W'(N_DOM - 1)) begin
                    dom_reset_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_PWR_ON;
                end
            end
            S_RELEASE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (drop) begin
                    go_err  = 1'b1;
                    err_idx = drop_idx;
                end else if (clr_i) begin
                    go_idle = 1'b1;
                end
            end
            S_ERROR: begin
                if (clr_i) begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_err) begin
            pwr_en_d    = '0;
            iso_d       = '1;
            dom_reset_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b1;
            err_dom_d   = err_idx;
            state_d     = S_ERROR;
        end

        // err_dom survives the return to idle for post-mortem reads
        if (go_idle) begin
            pwr_en_d    = '0;
            iso_d       = '1;
            dom_reset_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            idx_d       = '0;
            cnt_d       = '0;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            pwr_en_q    <= '0;
            iso_q       <= '1;
            dom_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_dom_q   <= '0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pwr_en_q    <= pwr_en_d;
            iso_q       <= iso_d;
            dom_reset_q <= dom_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_dom_q   <= err_dom_d;
        end
    end

    assign pwr_en_o    = pwr_en_q;
    assign iso_o       = iso_q;
    assign dom_reset_o = dom_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_dom_o   = err_dom_q;

endmodule

// File: tb/tb_puc_seq.sv
// Scoreboard bench for puc_seq: per-cycle expected output vectors are queued from the sequence timing,
// then popped and compared each cycle. Power-good follows the switch enables two cycles late.
module tb_puc_seq;

    localparam int unsigned N_DOM   = 2;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int          PG_LAT  = 2;

    typedef logic [8:0] vec_t;  // {pwr_en, iso, dom_reset, busy, done, err, err_dom}

    logic             clk_i    = 1'b0;
    logic             reset_ni = 1'b1;
    logic [N_DOM-1:0] puc_i;
    logic             start_i;
    logic             clr_i;
    logic [N_DOM-1:0] pg_i;
    logic [N_DOM-1:0] pwr_en_o;
    logic [N_DOM-1:0] iso_o;
    logic             dom_reset_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [0:0]       err_dom_o;

    logic [N_DOM-1:0] pg_d1, pg_d2, pg_mask;
    vec_t             got;
    vec_t             exp_q[$];
    logic [1:0]       e_pwr, e_iso;
    logic             e_edom;
    int               n_vec = 0;
    int               n_bad = 0;

    puc_seq #(
        .N_DOM  (N_DOM),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .puc_i      (puc_i),
        .start_i    (start_i),
        .clr_i      (clr_i),
        .pg_i       (pg_i),
        .pwr_en_o   (pwr_en_o),
        .iso_o      (iso_o),
        .dom_reset_o(dom_reset_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_dom_o  (err_dom_o)
    );

    always #5 clk_i = ~clk_i;

    // Power-good echoes the switch enables PG_LAT cycles later; pg_mask forces domains bad
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pg_d1 <= '0;
            pg_d2 <= '0;
        end else begin
            pg_d1 <= pwr_en_o;
            pg_d2 <= pg_d1;
        end
    end
    assign pg_i = pg_d2 & pg_mask;
    assign got  = {pwr_en_o, iso_o, dom_reset_o, busy_o, done_o, err_o, err_dom_o};

    task automatic check(input string tag, input vec_t obs, input vec_t want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (pwr iso rst busy done err edom)", tag, obs, want);
        end
    endtask

    function automatic vec_t idle_vec();
        return {2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, e_edom};
    endfunction

    task automatic push_busy(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({e_pwr, e_iso, 1'b1, 1'b1, 1'b0, 1'b0, e_edom});
    endtask

    task automatic push_done(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({e_pwr, e_iso, 1'b0, 1'b0, 1'b1, 1'b0, e_edom});
    endtask

    task automatic push_err(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, e_edom});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(idle_vec());
    endtask

    task automatic begin_run();
        e_pwr = 2'b00;
        e_iso = 2'b11;
    endtask

    // One domain slot: PWR_ON, then WAIT_PG/SETTLE/NEXT if permitted, else just NEXT
    task automatic gen_dom(input int i, input bit en);
        push_busy(1);
        if (en) begin
            e_pwr[i] = 1'b1;
            push_busy(PG_LAT + 1);
            push_busy(SETTLE);
            e_iso[i] = 1'b0;
            push_busy(1);
        end else begin
            push_busy(1);
        end
    endtask

    task automatic run(input string tag, input int chg_at, input logic [1:0] puc_new);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            clr_i   = 1'b0;
            k++;
            if (k == chg_at) puc_i = puc_new;
            check($sformatf("%s c%0d", tag, k), got, exp_q.pop_front());
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_ni = 1'b0;
        e_edom   = 1'b0;
        #1;
        check(tag, got, idle_vec());
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    initial begin
        puc_i   = '0;
        start_i = 1'b0;
        clr_i   = 1'b0;
        pg_mask = 2'b11;
        e_edom  = 1'b0;
        begin_run();

        #1 reset_ni = 1'b0;
        #2 check("reset", got, idle_vec());
        @(negedge clk_i);
        reset_ni = 1'b1;
        push_idle(3);
        run("idle", -1, 2'b00);

        // Both domains permitted
        puc_i = 2'b11;
        begin_run();
        gen_dom(0, 1'b1);
        gen_dom(1, 1'b1);
        push_done(3);
        start_i = 1'b1;
        run("seq11", -1, 2'b00);
        clr_i = 1'b1;
        push_idle(4);
        run("clr11", -1, 2'b00);

        // Domain 0 not permitted; contract change mid-run must be ignored
        puc_i = 2'b10;
        begin_run();
        gen_dom(0, 1'b0);
        gen_dom(1, 1'b1);
        push_done(2);
        start_i = 1'b1;
        run("seq10", 2, 2'b01);
        clr_i = 1'b1;
        push_idle(4);
        run("clr10", -1, 2'b00);

        // Domain 1 never reports power-good
        puc_i   = 2'b11;
        pg_mask = 2'b01;
        begin_run();
        gen_dom(0, 1'b1);
        push_busy(1);
        e_pwr[1] = 1'b1;
`ifdef PUC_SEQ_TIMEOUT_EN
        push_busy(TIMEOUT + 1);
        e_edom = 1'b1;
        push_err(3);
        start_i = 1'b1;
        run("tmo", -1, 2'b00);
        clr_i = 1'b1;
        push_idle(4);
        run("clr_err", -1, 2'b00);
`else
        push_busy(40);
        start_i = 1'b1;
        run("nowait", -1, 2'b00);
        async_reset("rst_wait");
        push_idle(4);
        run("idle_wait", -1, 2'b00);
`endif
        pg_mask = 2'b11;

        // Power-good drop on domain 0 while DONE
        begin_run();
        gen_dom(0, 1'b1);
        gen_dom(1, 1'b1);
        push_done(3);
        start_i = 1'b1;
        run("seq_drop", -1, 2'b00);
        pg_mask = 2'b10;
        e_edom  = 1'b0;
        push_err(2);
        run("drop", -1, 2'b00);
        pg_mask = 2'b11;
        clr_i   = 1'b1;
        push_idle(4);
        run("clr_drop", -1, 2'b00);

        // Reset in the middle of domain 1 SETTLE, then a clean rerun
        begin_run();
        gen_dom(0, 1'b1);
        push_busy(1);
        e_pwr[1] = 1'b1;
        push_busy(PG_LAT + 1);
        push_busy(2);
        start_i = 1'b1;
        run("pre_rst", -1, 2'b00);
        async_reset("rst_settle");
        push_idle(3);
        run("post_rst", -1, 2'b00);
        begin_run();
        gen_dom(0, 1'b1);
        gen_dom(1, 1'b1);
        push_done(2);
        start_i = 1'b1;
        run("clean", -1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/puc_seq.md
# puc_seq

Uncore power-up sequencer driven by the power-up contract. On a start request it snapshots the contract bits and brings each permitted uncore domain up in index order: enable the power switch, wait for power-good, settle, then drop isolation. Once every domain is handled it releases the shared uncore domain reset. It sits between the contract latch and the uncore power switches, isolation clamps and domain reset.

## Interface
- N_DOM, 2: number of uncore domains, which equals the contract width; must be ≥ 1.
- SETTLE, 4: cycles between power-good and isolation release; must be ≥ 1.
- TIMEOUT, 255: maximum cycles spent waiting for power-good.
- CNT_W, 8: counter width; must hold max(SETTLE, TIMEOUT).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- reset_ni  in  1  asynchronous, active-low reset.
- puc_i  in  N_DOM  contract bits; bit i=1 permits domain i.
- start_i  in  1  start request, sampled in IDLE only.
- clr_i  in  1  return to IDLE from DONE or ERROR.
- pg_i  in  N_DOM  power-good per domain.
- pwr_en_o  out  N_DOM  power switch enable.
- iso_o  out  N_DOM  isolation clamp, 1 = isolated.
- dom_reset_o  out  1  active-high uncore domain reset.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete.
- err_o  out  1  sequence failed.
- err_dom_o  out  IDX_W  index of the failing domain; IDX_W = max(1, $clog2(N_DOM)).

## Operation
- All outputs are registered.
- Reset values: pwr_en_o=0, iso_o=all 1, dom_reset_o=1, busy_o=0, done_o=0, err_o=0, err_dom_o=0. State is IDLE, idx=0, cnt=0.
- IDLE: when start_i=1, snapshot puc_i into cap, set idx=0, set busy_o=1, go to PWR_ON. Later changes on puc_i are ignored until the next start.
- PWR_ON:
  - If cap[idx]=0, the domain stays off and isolated; go to NEXT.
  - Otherwise set pwr_en_o[idx]=1, clear cnt, go to WAIT_PG.
- WAIT_PG:
  - If pg_i[idx]=1, clear cnt and go to SETTLE.
  - Else increment cnt. When cnt reaches TIMEOUT, go to ERROR.
- SETTLE: increment cnt. On the cycle cnt reaches SETTLE-1, clear iso_o[idx] and go to NEXT.
- NEXT: if idx = N_DOM-1, go to RELEASE; else increment idx and go to PWR_ON.
- RELEASE: set dom_reset_o=0, busy_o=0, done_o=1, go to DONE. This happens even if cap is all zero.
- DONE:
  - A pg_i[i]=0 on any domain with cap[i]=1 goes to ERROR with err_dom_o=i. If several drop, the lowest index wins.
  - Otherwise clr_i=1 goes to IDLE.
- ERROR (entry):
  - pwr_en_o=0, iso_o=all 1, dom_reset_o=1, busy_o=0, done_o=0, err_o=1.
  - err_dom_o = idx, or the dropping index when entered from DONE.
  - Only clr_i=1 leaves ERROR, going to IDLE with err_o=0 and err_dom_o held.
- IDLE entry from clr_i: every output returns to its reset value except err_dom_o.
- start_i outside IDLE and clr_i outside DONE/ERROR are ignored.
- pg_i is sampled directly. Synchronisation of pg_i is the integrator's job.
- Reset asserted at any point returns immediately to reset values, including mid-sequence with switches on.

## Timing
- start_i sampled at edge 0 → PWR_ON in cycle 1 → pwr_en_o[0] visible in cycle 2 (WAIT_PG).
- With pg_i already high, SETTLE spans cycles 3 to 3+SETTLE-1. iso_o[0] falls at cycle 3+SETTLE, in NEXT.
- Per enabled domain: 3+SETTLE cycles from PWR_ON entry to the next PWR_ON, plus one cycle per cycle pg_i is late.
- Per skipped domain: 2 cycles (PWR_ON, NEXT).
- dom_reset_o falls and done_o rises one cycle after the final NEXT.
- Timeout: ERROR is entered TIMEOUT+1 cycles after WAIT_PG entry when pg_i stays low.

## Configuration
- PUC_SEQ_TIMEOUT_EN defined: the WAIT_PG timeout is active as described.
- PUC_SEQ_TIMEOUT_EN undefined: WAIT_PG waits indefinitely. Only a power-good drop in DONE reaches ERROR, and the TIMEOUT parameter is unused.

## Test plan
Bench settings for all scenarios: N_DOM=2, SETTLE=4, TIMEOUT=16.
- Reset then idle: pwr_en_o=00, iso_o=11, dom_reset_o=1, all flags 0.
- puc_i=11, pg_i follows pwr_en_o after 2 cycles, start pulse → pwr_en_o 01 then 11; iso_o 10 then 00; done_o=1; dom_reset_o=0 exactly one cycle after iso_o=00.
- puc_i=10, start → domain 0 skipped (pwr_en_o[0]=0, iso_o[0]=1); only domain 1 powered; done_o=1. Changing puc_i to 01 mid-sequence has no effect.
- puc_i=11, pg_i[1] held 0 (macro defined) → ERROR 17 cycles after WAIT_PG entry for domain 1; err_o=1, err_dom_o=1, pwr_en_o=00, iso_o=11. clr_i → IDLE, err_o=0.
- In DONE with puc_i=11, drop pg_i[0] → err_o=1, err_dom_o=0, dom_reset_o=1 next cycle.
- Deassert reset_ni while in SETTLE of domain 1 → outputs reach reset values asynchronously; a later start runs a full clean sequence.
